// File: rtl/syncount_updown.sv
// Parametrised synchronous modulo-N up/down counter with enable, parallel load,
// terminal count and wrap pulse. Define SYNCNT_SAT_EN to saturate instead of wrap.
module syncount_updown #(
    parameter int WIDTH     = 4,
    parameter int MODULO    = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    // One extra bit so MODULO = 2^WIDTH is representable in the clamp compare
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_next;

    assign at_max       = (count_o == MAX_VAL);
    assign at_zero      = (count_o == '0);
    assign load_clamped = ({1'b0, load_val_i} >= MOD_EXT) ? MAX_VAL : load_val_i;

    assign tc_o = en_i & ~load_i & ((up_i & at_max) | (~up_i & at_zero));

`ifdef SYNCNT_SAT_EN
    // Terminal values are sticky in the current direction
    assign count_next = up_i ? (at_max  ? MAX_VAL : count_o + WIDTH'(1))
                             : (at_zero ? '0      : count_o - WIDTH'(1));
    assign wrap_o = 1'b0;
`else
    // Explicit wrap compare keeps intermediate values below MODULO for any modulus
    assign count_next = up_i ? (at_max  ? '0      : count_o + WIDTH'(1))
                             : (at_zero ? MAX_VAL : count_o - WIDTH'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrap_o <= 1'b0;
        end else begin
            wrap_o <= tc_o;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= RST_VAL;
        end else if (load_i) begin
            count_o <= load_clamped;
        end else if (en_i) begin
            count_o <= count_next;
        end
    end

endmodule

// File: tb/tb_syncount_updown.sv
// Directed bench for syncount_updown: modulo-10 instance plus a modulo-8
// (full binary range, non-zero reset value) instance.
module tb_syncount_updown;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] lv;
    logic [3:0] count;
    logic       tc;
    logic       wrap;

    logic       en2;
    logic [2:0] count2;
    logic       tc2;
    logic       wrap2;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    syncount_updown #(.WIDTH(4), .MODULO(10), .RESET_VAL(0)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load),
        .load_val_i(lv), .count_o(count), .tc_o(tc), .wrap_o(wrap)
    );

    syncount_updown #(.WIDTH(3), .MODULO(8), .RESET_VAL(5)) dut2 (
        .clk_i(clk), .rst_i(rst), .en_i(en2), .up_i(1'b1), .load_i(1'b0),
        .load_val_i(3'd0), .count_o(count2), .tc_o(tc2), .wrap_o(wrap2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1;
        lv   = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = 4'd0; en2 = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_count2", count2, 5);
        chk("rst_wrap2", wrap2, 0);
        tick();
        tick();
        chk("rst_hold_count", count, 0);
        chk("rst_hold_count2", count2, 5);
        rst = 1'b0;

`ifndef SYNCNT_SAT_EN
        // up-count through the 9 -> 0 wrap; dut2 wraps 7 -> 0 naturally
        en = 1'b1; up = 1'b1; en2 = 1'b1;
        #1;
        chk("up_tc_at0", tc, 0);
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk($sformatf("up_count_%0d", i), count, i % 10);
            chk($sformatf("up_tc_%0d", i), tc, (i % 10) == 9);
            chk($sformatf("up_wrap_%0d", i), wrap, i == 10);
            chk($sformatf("m8_count_%0d", i), count2, (5 + i) % 8);
            chk($sformatf("m8_tc_%0d", i), tc2, ((5 + i) % 8) == 7);
            chk($sformatf("m8_wrap_%0d", i), wrap2, ((5 + i) % 8) == 0);
        end
        en2 = 1'b0;
`endif

        // asynchronous reset mid-count at 6
        en = 1'b0;
        do_load(4'd6);
        chk("pre_rst_count", count, 6);
        en = 1'b1; up = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_wrap", wrap, 0);
        tick();
        chk("rst_held_count_a", count, 0);
        tick();
        chk("rst_held_count_b", count, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_first", count, 1);

`ifndef SYNCNT_SAT_EN
        en = 1'b0;
        do_load(4'd0);
        en = 1'b1; up = 1'b0;
        #1;
        chk("dn_tc_at0", tc, 1);
        tick();
        chk("dn_count_9", count, 9);
        chk("dn_wrap_9", wrap, 1);
        chk("dn_tc_9", tc, 0);
        tick();
        chk("dn_count_8", count, 8);
        chk("dn_wrap_8", wrap, 0);
        tick();
        chk("dn_count_7", count, 7);

        // direction reversal at the terminal values
        do_load(4'd9);
        up = 1'b1;
        #1;
        chk("rev_tc_up9", tc, 1);
        tick();
        chk("rev_count_0", count, 0);
        chk("rev_wrap_0", wrap, 1);
        up = 1'b0;
        #1;
        chk("rev_tc_dn0", tc, 1);
        tick();
        chk("rev_count_9", count, 9);
        chk("rev_wrap_9", wrap, 1);
        up = 1'b1;
        #1;
        chk("rev_tc_up9b", tc, 1);
`else
        en = 1'b0;
        do_load(4'd8);
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("sat_up_count_%0d", i), count, 9);
            chk($sformatf("sat_up_tc_%0d", i), tc, 1);
            chk($sformatf("sat_up_wrap_%0d", i), wrap, 0);
        end
        do_load(4'd1);
        up = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            chk($sformatf("sat_dn_count_%0d", i), count, 0);
            chk($sformatf("sat_dn_tc_%0d", i), tc, 1);
            chk($sformatf("sat_dn_wrap_%0d", i), wrap, 0);
        end
`endif

        // load priority over count, and clamping
        en = 1'b0;
        do_load(4'd3);
        chk("ld_count_3", count, 3);
        en = 1'b1; up = 1'b1; load = 1'b1; lv = 4'd7;
        tick();
        chk("ld_count_7", count, 7);
        chk("ld_wrap_7", wrap, 0);
        chk("ld_tc_7", tc, 0);
        lv = 4'd12;
        tick();
        chk("ld_clamp_12", count, 9);
        #1;
        chk("ld_tc_masked", tc, 0);
        lv = 4'd15;
        tick();
        chk("ld_clamp_15", count, 9);
        chk("ld_wrap_15", wrap, 0);
        lv = 4'd10;
        tick();
        chk("ld_clamp_10", count, 9);
        load = 1'b0;
        #1;
        chk("ld_release_tc", tc, 1);
        en = 1'b0;
        #1;
        chk("hold_tc_masked", tc, 0);
        tick();
        chk("hold_at9_count", count, 9);
        chk("hold_at9_wrap", wrap, 0);

        // hold then single steps in each direction
        do_load(4'd5);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("hold_count_%0d", i), count, 5);
            chk($sformatf("hold_wrap_%0d", i), wrap, 0);
        end
        en = 1'b1; up = 1'b1;
        tick();
        chk("step_up_6", count, 6);
        up = 1'b0;
        tick();
        chk("step_dn_5", count, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
